mux_stream_n: RTL and testbench

MUX_STREAM_N -- requirements
Module: mux_stream_n

---
 rtl/mux_stream_n.sv | 232 +++++++++++++++++++++++
 tb/tb_mux_stream_n.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_n.sv
// mux_stream_n -- N-channel packet-aware stream multiplexer.
//
// Picks one input channel at a time and forwards its beats to a single
// registered output stage. Once a non-last beat is accepted from a channel,
// that channel stays locked until its last beat is accepted, so packets never
// interleave at the output.
//
// Configuration macro:
//   MUX_STREAM_N_RR_EN  defined   -> round-robin arbitration with a pointer
//                                    that moves past the channel that just
//                                    finished a packet.
//                       undefined -> fixed priority, lowest index wins.
//
// Parameters:
//   N      number of input channels (>= 2)
//   WIDTH  data bits per channel
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel last-beat flag
//   in_ready   per-channel accept (combinational, at most one bit high)
//   out_data   registered data of the held beat
//   out_last   registered last flag of the held beat
//   out_sel    registered source channel of the held beat
//   out_valid  output beat valid
//   out_ready  downstream accept
module mux_stream_n #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  input  logic [N-1:0]           in_last,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [$clog2(N)-1:0]   out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SW  = $clog2(N);
  localparam int SW1 = SW + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [SW-1:0]      grant_r;
  logic [SW-1:0]      grant_nx_s;

  logic [WIDTH-1:0]   out_data_r;
  logic               out_last_r;
  logic [SW-1:0]      out_sel_r;
  logic               out_valid_r;

  logic               load_ok_s;
  logic               any_valid_s;
  logic [SW-1:0]      win_s;
  logic [SW-1:0]      sel_s;
  logic [N-1:0]       in_ready_s;
  logic               xfer_s;
  logic [WIDTH-1:0]   sel_data_s;
  logic               sel_last_s;

`ifdef MUX_STREAM_N_RR_EN
  logic [SW-1:0]      ptr_r;
  logic [SW:0]        cand_s;
  logic [SW:0]        ptr_nx_s;
`endif

  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_s;

  // The output register can take a new beat when empty or being drained.
  assign load_ok_s   = !out_valid_r || out_ready;
  assign any_valid_s = |in_valid;

`ifdef MUX_STREAM_N_RR_EN
  // Round-robin winner: scan offsets from the pointer downwards so the
  // smallest offset (closest to the pointer) is the last one written.
  always_comb begin
    win_s  = '0;
    cand_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr_r} + SW1'(k);
      if (cand_s >= SW1'(N)) begin
        cand_s = cand_s - SW1'(N);
      end else begin
        cand_s = cand_s;
      end
      if (in_valid[cand_s[SW-1:0]]) begin
        win_s = cand_s[SW-1:0];
      end else begin
        win_s = win_s;
      end
    end
  end
`else
  // Fixed-priority winner: scanning downwards leaves the lowest valid index.
  always_comb begin
    win_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        win_s = SW'(k);
      end else begin
        win_s = win_s;
      end
    end
  end
`endif

  // Selected channel is the lock holder when locked, otherwise the winner.
  assign sel_s = (state_r == LOCKED) ? grant_r : win_s;

  // Grant the selected channel only; nothing is accepted while in reset.
  always_comb begin
    in_ready_s = '0;
    if (!rst_n) begin
      in_ready_s = '0;
    end else if (state_r == LOCKED) begin
      in_ready_s[grant_r] = load_ok_s;
    end else if (any_valid_s) begin
      in_ready_s[win_s] = load_ok_s;
    end else begin
      in_ready_s = '0;
    end
  end

  assign xfer_s = |(in_valid & in_ready_s);

  // Mux the data and last flag of the selected channel.
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_s == SW'(k)) begin
        sel_data_s = in_data[k*WIDTH +: WIDTH];
        sel_last_s = in_last[k];
      end else begin
        sel_data_s = sel_data_s;
        sel_last_s = sel_last_s;
      end
    end
  end

  // Lock on a non-last beat from IDLE, release on the last beat.
  always_comb begin
    state_nx_s = state_r;
    grant_nx_s = grant_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && !sel_last_s) begin
          state_nx_s = LOCKED;
          grant_nx_s = win_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && sel_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = LOCKED;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Arbiter state and output beat register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_sel_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      grant_r <= grant_nx_s;
      if (xfer_s) begin
        out_data_r  <= sel_data_s;
        out_last_r  <= sel_last_s;
        out_sel_r   <= sel_s;
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef MUX_STREAM_N_RR_EN
  // Pointer moves just past the channel whose packet ends, modulo N.
  always_comb begin
    ptr_nx_s = {1'b0, sel_s} + SW1'(1);
    if (ptr_nx_s >= SW1'(N)) begin
      ptr_nx_s = '0;
    end else begin
      ptr_nx_s = ptr_nx_s;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s && sel_last_s) begin
      ptr_r <= ptr_nx_s[SW-1:0];
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

endmodule

// File: tb/tb_mux_stream_n.sv
module tb_mux_stream_n;

  localparam int N = 4;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic [3:0]    out_data;
  logic          out_last;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          out_ready;

  mux_stream_n #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet owner (-1 = none), RR pointer, held output beat.
  int          m_owner = -1;
  int          m_ptr   = 0;
  logic        m_oval  = 1'b0;
  logic        m_olast = 1'b0;
  logic [3:0]  m_odata = 4'h0;
  int          m_osel  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int ch;
    int c;
    r  = 4'b0000;
    ch = -1;
    if (rst_n !== 1'b1) return 4'b0000;
    if (m_owner >= 0) ch = m_owner;
    else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (ch < 0 && in_valid[c]) ch = c;
      end
    end
    if (ch >= 0) r[ch] = (!m_oval) || out_ready;
    return r;
  endfunction

  // Check comb ready and held outputs, advance one clock, update the model.
  task automatic tick(input string tag);
    logic [3:0] er;
    int c;
    #1;
    er = exp_ready();
    chk({tag, ":in_ready"}, in_ready, er);
    chk({tag, ":out_valid"}, out_valid, m_oval);
    chk({tag, ":out_data"}, out_data, m_odata);
    chk({tag, ":out_last"}, out_last, m_olast);
    chk({tag, ":out_sel"}, out_sel, m_osel);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_owner = -1; m_ptr = 0; m_oval = 1'b0; m_olast = 1'b0; m_odata = 4'h0; m_osel = 0;
    end else begin
      c = -1;
      for (int k = 0; k < N; k++) if (in_valid[k] && er[k]) c = k;
      if (c >= 0) begin
        m_odata = in_data[c*W +: W];
        m_olast = in_last[c];
        m_osel  = c;
        m_oval  = 1'b1;
        if (in_last[c]) begin
          m_owner = -1;
`ifdef MUX_STREAM_N_RR_EN
          m_ptr = (c + 1) % N;
`endif
        end else m_owner = c;
      end else if (out_ready) m_oval = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 4'b0000;
    tick("rst");
    rst_n = 1'b1;
    chk("rst:out_valid", out_valid, 1'b0);
    chk("rst:out_data", out_data, 4'h0);
    chk("rst:out_sel", out_sel, 2'd0);
    chk("rst:out_last", out_last, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_oval;
    logic [3:0]  e_data;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t tbl[6];
  int exp_sel;

  initial begin
    tbl[0] = '{4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
    tbl[1] = '{4'b0000, 16'h1234, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
    tbl[2] = '{4'b1010, 16'h7050, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
    tbl[3] = '{4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    tbl[4] = '{4'b1000, 16'hF000, 1'b0, 4'b1000, 1'b1, 4'hF, 2'd3};
    tbl[5] = '{4'b1100, 16'hC900, 1'b1, 4'b0100, 1'b1, 4'h9, 2'd2};

    rst_n = 1'b0; in_data = 16'h0; in_valid = 4'h0; in_last = 4'h0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Table: single last-beats from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = 4'hF; out_ready = tbl[i].ordy;
      #1;
      chk("tbl:in_ready", in_ready, tbl[i].e_rdy);
      tick("tbl");
      chk("tbl:out_valid", out_valid, tbl[i].e_oval);
      chk("tbl:out_data", out_data, tbl[i].e_data);
      chk("tbl:out_sel", out_sel, tbl[i].e_sel);
      chk("tbl:out_last", out_last, tbl[i].e_oval);
      in_valid = 4'h0;
    end

    // Lock: ch1 packet 1,2,3 while ch0 keeps asking; ch1 drops valid mid-packet.
    do_reset();
    out_ready = 1'b1; in_last = 4'b0001;
    in_valid = 4'b0010; in_data = 16'h001E;
    tick("lock1");
    chk("lock1:data", out_data, 4'h1); chk("lock1:sel", out_sel, 2'd1);
    in_valid = 4'b0001;
    #1; chk("lockgap:rdy0", in_ready[0], 1'b0);
    tick("lockgap");
    chk("lockgap:oval", out_valid, 1'b0);
    in_valid = 4'b0011; in_data = 16'h002E;
    #1; chk("lock2:rdy0", in_ready[0], 1'b0);
    tick("lock2");
    chk("lock2:data", out_data, 4'h2); chk("lock2:sel", out_sel, 2'd1);
    in_data = 16'h003E; in_last = 4'b0011;
    #1; chk("lock3:rdy0", in_ready[0], 1'b0);
    tick("lock3");
    chk("lock3:data", out_data, 4'h3); chk("lock3:last", out_last, 1'b1);
    in_valid = 4'b0001;
    tick("lock4");
    chk("lock4:sel", out_sel, 2'd0); chk("lock4:data", out_data, 4'hE);
    in_valid = 4'h0;

    // Backpressure then release with no bubble.
    do_reset();
    out_ready = 1'b0; in_data = 16'hB005; in_last = 4'b1001; in_valid = 4'b0001;
    tick("bp0");
    chk("bp0:data", out_data, 4'h5);
    in_valid = 4'b1000;
    #1; chk("bp1:rdy", in_ready, 4'b0000);
    tick("bp1"); chk("bp1:hold", out_data, 4'h5);
    tick("bp2"); chk("bp2:hold", out_data, 4'h5);
    out_ready = 1'b1;
    #1; chk("bp3:rdy", in_ready, 4'b1000);
    tick("bp3");
    chk("bp3:oval", out_valid, 1'b1); chk("bp3:data", out_data, 4'hB); chk("bp3:sel", out_sel, 2'd3);
    in_valid = 4'h0;
    tick("bp4"); chk("bp4:oval", out_valid, 1'b0);

    // Arbitration order with all channels valid.
    do_reset();
    out_ready = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      tick("arb");
`ifdef MUX_STREAM_N_RR_EN
      exp_sel = i % 4;
`else
      exp_sel = 0;
`endif
      chk("arb:sel", out_sel, exp_sel);
      chk("arb:data", out_data, exp_sel + 1);
    end
    in_valid = 4'h0;

    // Reset mid-packet drops the lock.
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; in_data = 16'h0700;
    tick("rmp0"); chk("rmp0:sel", out_sel, 2'd2);
    rst_n = 1'b0;
    tick("rmp1");
    rst_n = 1'b1;
    chk("rmp1:oval", out_valid, 1'b0);
    in_valid = 4'b0101; in_last = 4'b0001; in_data = 16'h0709;
    #1; chk("rmp2:rdy", in_ready, 4'b0001);
    tick("rmp2");
    chk("rmp2:sel", out_sel, 2'd0); chk("rmp2:data", out_data, 4'h9);
    in_valid = 4'h0;

    // Throughput: 8 beats on consecutive cycles.
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'((k + 1) << 4);
      in_last = (k == 7) ? 4'b0010 : 4'b0000;
      tick("thr");
      chk("thr:oval", out_valid, 1'b1);
      chk("thr:data", out_data, k + 1);
      chk("thr:sel", out_sel, 2'd1);
    end
    in_valid = 4'h0;
    tick("thr9"); chk("thr9:oval", out_valid, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
